mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM-stage data-bus master that completes what EXE prepares: issues one load/store per
//  accepted op on a req/addr_ok/data_ok SRAM-style bus, then aligns and extends load data
//  for writeback. Aligned LB/LBU/LH/LHU/LW, plus LWL/LWR merge with the old rt value.
//  Sits between the EXE->MEM pipeline register and the WB stage; one op in flight.
// PARAMETERS
//  ADDR_W   32  data-bus address width
//  DATA_W   32  data width (fixed 32; byte lanes 3..0, little-endian)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, synchronous, active-low
//  in_valid     in   1   EXE op valid
//  in_ready     out  1   stage can accept op
//  in_ltype     in   3   0 none,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 LWL,7 LWR
//  in_wstrb     in   4   store byte enables, pre-aligned by EXE (0 = not a store)
//  in_addr      in   32  byte address (ALU result)
//  in_wdata     in   32  store data, pre-aligned
//  in_rt_old    in   32  current rt value, for LWL/LWR merge
//  in_waddr     in   5   destination register
//  in_flush     in   1   exception/eret flush: cancel current op
//  data_req     out  1   bus request
//  data_wr      out  1   1 = write
//  data_wstrb   out  4   write strobes
//  data_addr    out  32  {in_addr[31:2],2'b00}
//  data_wdata   out  32  write data
//  data_addr_ok in   1   request accepted this cycle
//  data_rdata   in   32  read data, valid with data_ok
//  data_data_ok in   1   transaction complete
//  out_valid    out  1   result to WB valid
//  out_ready    in   1   WB accepts
//  out_wen      out  1   register write (1 for loads, 0 stores/none)
//  out_waddr    out  5   destination register
//  out_wdata    out  32  aligned/extended/merged load result
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): state IDLE, cancel=0, data_req=0, out_valid=0, out_wen=0,
//    out_waddr=0, out_wdata=0, all latched op fields 0. Reset mid-transaction abandons it.
//  - FSM IDLE->REQ->WAIT->DONE->IDLE. in_ready=1 only in IDLE.
//  - IDLE: in_valid & ~in_flush -> latch op; if ltype==0 & wstrb==0 go DONE (no bus op),
//    else REQ. in_valid & in_flush -> op dropped, stay IDLE.
//  - REQ: data_req=1, fields stable from latch. Held until data_addr_ok; then WAIT. No
//    withdrawal once asserted, even on flush.
//  - WAIT: on data_data_ok latch aligned result, go DONE. data_ok in same cycle as addr_ok
//    is not permitted (bus guarantees >=1 cycle); data_ok outside WAIT ignored.
//  - DONE: out_valid=1 unless cancel; on out_ready (or cancel) -> IDLE. Outputs held stable
//    while out_valid & ~out_ready.
//  - in_flush in REQ/WAIT sets cancel: bus transaction still completes, result discarded,
//    no out_valid. in_flush in DONE drops the result that cycle. cancel cleared in IDLE.
//  - Min latency: accept T, req T+1, addr_ok T+1, data_ok T+2, out_valid T+3.
//  - Alignment, a=addr[1:0], r=rdata, t=rt_old:
//    LB/LBU: byte r[8a+7:8a], sign/zero-ext. LH/LHU: a[1]?r[31:16]:r[15:0], ext.
//    LW: r. LWL a=0..3: {r[7:0],t[23:0]},{r[15:0],t[15:0]},{r[23:0],t[7:0]},r.
//    LWR a=0..3: r,{t[31:24],r[31:8]},{t[31:16],r[31:16]},{t[31:8],r[31:24]}.
//  - Misaligned LH/LW are filtered by EXE (AdEL); this block ignores a[0] for LH, a for LW.
//  - Store completes on data_ok with out_wen=0, out_wdata=0.
// STRUCTURE
//  - Shared package: LTYPE_* encodings (3-bit), FSM state encodings.
//  - Sub-module load_align (combinational: ltype, a, r, t -> 32-bit result); FSM, latches
//    and handshake stay in mem_access_stage.
// TESTING
//  - LB a=3, r=0x80123456 -> out_wdata=0xFFFFFF80; LBU same -> 0x00000080; out_wen=1.
//  - LH a=2, r=0x8001_7FFF -> 0xFFFF8001; LHU a=0 -> 0x00007FFF.
//  - LWL a=1, r=0xAABBCCDD, t=0x11223344 -> 0xCCDD3344; LWR a=1 -> 0x11AABBCC.
//  - SW wstrb=4'hF addr=0x1003: data_addr=0x1000, data_wr=1, held 3 cycles until addr_ok;
//    out_valid with out_wen=0 after data_ok.
//  - in_flush during WAIT: data_ok still consumed, no out_valid; next op accepted in IDLE.
//  - out_ready low 4 cycles in DONE: outputs stable, in_ready=0; rst low mid-WAIT -> IDLE,
//    data_req=0, out_valid=0 next cycle.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: load-type encodings and FSM states shared by the MEM stage
package mem_access_stage_pkg;
    localparam logic [2:0] LTYPE_NONE = 3'd0;
    localparam logic [2:0] LTYPE_LB   = 3'd1;
    localparam logic [2:0] LTYPE_LBU  = 3'd2;
    localparam logic [2:0] LTYPE_LH   = 3'd3;
    localparam logic [2:0] LTYPE_LHU  = 3'd4;
    localparam logic [2:0] LTYPE_LW   = 3'd5;
    localparam logic [2:0] LTYPE_LWL  = 3'd6;
    localparam logic [2:0] LTYPE_LWR  = 3'd7;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_e;
endpackage

// File: rtl/mem_access_stage_load_align.sv
// mem_access_stage_load_align: aligns, extends and merges raw load data for writeback
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  ltype,
    input  logic [1:0]  a,
    input  logic [31:0] r,
    input  logic [31:0] t,
    output logic [31:0] res
);
    logic [4:0]  sh;
    logic [4:0]  shl;
    logic [7:0]  b;
    logic [15:0] h;
    // LWL shifts the word up by 3-a bytes, LWR down by a bytes; the rest of rt is kept
    always_comb begin
        sh  = {a, 3'b000};
        shl = {~a, 3'b000};
        b   = 8'(r >> sh);
        h   = a[1] ? r[31:16] : r[15:0];
        res = (ltype == LTYPE_LB)  ? {{24{b[7]}}, b} :
              (ltype == LTYPE_LBU) ? {24'h0, b} :
              (ltype == LTYPE_LH)  ? {{16{h[15]}}, h} :
              (ltype == LTYPE_LHU) ? {16'h0, h} :
              (ltype == LTYPE_LW)  ? r :
              (ltype == LTYPE_LWL) ? ((r << shl) | (t & (32'h00FF_FFFF >> sh))) :
              (ltype == LTYPE_LWR) ? ((r >> sh) | (t & ~(32'hFFFF_FFFF >> sh))) : 32'h0;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage data-bus master, one load/store in flight, aligned writeback
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_ltype,
    input  logic [3:0]        in_wstrb,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_rt_old,
    input  logic [4:0]        in_waddr,
    input  logic              in_flush,
    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_data_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wen,
    output logic [4:0]        out_waddr,
    output logic [DATA_W-1:0] out_wdata
);
    state_e            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic [2:0]        ltype_q, ltype_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rt_q, rt_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] align_res;

    mem_access_stage_load_align u_align (
        .ltype (ltype_q),
        .a     (addr_q[1:0]),
        .r     (data_rdata),
        .t     (rt_q),
        .res   (align_res)
    );

    // State and latched op registers; reset abandons any transaction in progress
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cancel_q <= 1'b0;
            ltype_q  <= '0;
            wstrb_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rt_q     <= '0;
            waddr_q  <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            ltype_q  <= ltype_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rt_q     <= rt_d;
            waddr_q  <= waddr_d;
            res_q    <= res_d;
        end
    end

    // Next state and handshakes; a flush mid-bus only marks the op cancelled
    always_comb begin
        state_d   = state_q;
        cancel_d  = cancel_q;
        ltype_d   = ltype_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rt_d      = rt_q;
        waddr_d   = waddr_q;
        res_d     = res_q;
        in_ready  = 1'b0;
        data_req  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                cancel_d = 1'b0;
                if (in_valid && !in_flush) begin
                    ltype_d = in_ltype;
                    wstrb_d = in_wstrb;
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    rt_d    = in_rt_old;
                    waddr_d = in_waddr;
                    res_d   = '0;
                    state_d = (in_ltype == LTYPE_NONE && in_wstrb == 4'h0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                data_req = 1'b1;
                cancel_d = cancel_q | in_flush;
                if (data_addr_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cancel_d = cancel_q | in_flush;
                if (data_data_ok) begin
                    res_d   = (ltype_q != LTYPE_NONE) ? align_res : '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = !cancel_q && !in_flush;
                if (out_ready || cancel_q || in_flush) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_wr    = |wstrb_q;
    assign data_wstrb = wstrb_q;
    assign data_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign data_wdata = wdata_q;
    assign out_wen    = ltype_q != LTYPE_NONE;
    assign out_waddr  = waddr_q;
    assign out_wdata  = res_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and random load/store checks against a byte-level model
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_ltype = '0;
    logic [3:0]  in_wstrb = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [31:0] in_rt_old = '0;
    logic [4:0]  in_waddr = '0;
    logic        in_flush = 1'b0;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        data_data_ok = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_wen;
    logic [4:0]  out_waddr;
    logic [31:0] out_wdata;

    int checks = 0;
    int errors = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ltype(in_ltype), .in_wstrb(in_wstrb),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rt_old(in_rt_old), .in_waddr(in_waddr),
        .in_flush(in_flush),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
        .data_data_ok(data_data_ok),
        .out_valid(out_valid), .out_ready(out_ready), .out_wen(out_wen),
        .out_waddr(out_waddr), .out_wdata(out_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load result built byte by byte from the architectural rules
    function automatic logic [31:0] model(input logic [2:0] lt, input logic [1:0] a,
                                          input logic [31:0] r, input logic [31:0] t);
        logic [7:0] rb[4];
        logic [7:0] tt[4];
        logic [7:0] ob[4];
        logic [15:0] hw;
        int ai;
        ai = int'(a);
        for (int i = 0; i < 4; i++) begin
            rb[i] = r[8*i +: 8];
            tt[i] = t[8*i +: 8];
        end
        hw = (ai >= 2) ? {rb[3], rb[2]} : {rb[1], rb[0]};
        case (lt)
            3'd1: return {{24{rb[ai][7]}}, rb[ai]};
            3'd2: return {24'h0, rb[ai]};
            3'd3: return {{16{hw[15]}}, hw};
            3'd4: return {16'h0, hw};
            3'd5: return r;
            3'd6: begin
                for (int i = 0; i < 4; i++)
                    if (i >= 3 - ai) ob[i] = rb[i - 3 + ai];
                    else ob[i] = tt[i];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            3'd7: begin
                for (int i = 0; i < 4; i++)
                    if (i <= 3 - ai) ob[i] = rb[i + ai];
                    else ob[i] = tt[i];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            default: return 32'h0;
        endcase
    endfunction

    // Runs one op end to end; starts and ends just after a falling edge
    task automatic op(input string tag, input logic [2:0] lt, input logic [3:0] ws,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rt,
                      input logic [4:0] wa, input logic [31:0] rd,
                      input int ad, input int dd, input int stall);
        logic        bus;
        logic [31:0] exp_res;
        bus = (lt != 3'd0) || (ws != 4'h0);
        exp_res = (lt != 3'd0) ? model(lt, addr[1:0], rd, rt) : 32'h0;
        chk($sformatf("%s.in_ready_idle", tag), in_ready, 1);
        in_valid = 1'b1; in_ltype = lt; in_wstrb = ws; in_addr = addr;
        in_wdata = wd; in_rt_old = rt; in_waddr = wa;
        @(negedge clk);
        in_valid = 1'b0; in_ltype = $urandom; in_addr = $urandom; in_rt_old = $urandom;
        if (bus) begin
            for (int k = 0; k <= ad; k++) begin
                chk($sformatf("%s.req", tag), data_req, 1);
                chk($sformatf("%s.addr", tag), data_addr, {addr[31:2], 2'b00});
                chk($sformatf("%s.wr", tag), data_wr, ws != 4'h0);
                chk($sformatf("%s.wstrb", tag), data_wstrb, ws);
                chk($sformatf("%s.wdata", tag), data_wdata, wd);
                if (k == ad) data_addr_ok = 1'b1;
                @(negedge clk);
                data_addr_ok = 1'b0;
            end
            chk($sformatf("%s.req_drop", tag), data_req, 0);
            repeat (dd - 1) begin
                chk($sformatf("%s.no_early_out", tag), out_valid, 0);
                @(negedge clk);
            end
            data_data_ok = 1'b1; data_rdata = rd;
            @(negedge clk);
            data_data_ok = 1'b0; data_rdata = $urandom;
        end
        for (int k = 0; k <= stall; k++) begin
            chk($sformatf("%s.out_valid", tag), out_valid, 1);
            chk($sformatf("%s.in_ready_busy", tag), in_ready, 0);
            chk($sformatf("%s.wen", tag), out_wen, lt != 3'd0);
            chk($sformatf("%s.waddr", tag), out_waddr, wa);
            chk($sformatf("%s.wdata_out", tag), out_wdata, exp_res);
            if (k == stall) out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk($sformatf("%s.back_idle", tag), in_ready, 1);
        chk($sformatf("%s.out_gone", tag), out_valid, 0);
    endtask

    initial begin
        logic [2:0]  lt;
        logic [3:0]  ws;
        logic [3:0]  strb_tab[7];
        strb_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        repeat (3) @(negedge clk);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.data_req", data_req, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_wen", out_wen, 0);
        chk("rst.out_waddr", out_waddr, 0);
        chk("rst.out_wdata", out_wdata, 0);
        rst = 1'b1;

        op("lb",   3'd1, 4'h0, 32'h0000_2003, 32'h0, 32'h0, 5'd3, 32'h8012_3456, 0, 1, 0);
        op("lbu",  3'd2, 4'h0, 32'h0000_2003, 32'h0, 32'h0, 5'd4, 32'h8012_3456, 1, 2, 0);
        op("lh",   3'd3, 4'h0, 32'h0000_2002, 32'h0, 32'h0, 5'd5, 32'h8001_7FFF, 0, 1, 1);
        op("lhu",  3'd4, 4'h0, 32'h0000_2000, 32'h0, 32'h0, 5'd6, 32'h8001_7FFF, 2, 1, 0);
        op("lwl",  3'd6, 4'h0, 32'h0000_3001, 32'h0, 32'h1122_3344, 5'd7, 32'hAABB_CCDD, 0, 1, 0);
        op("lwr",  3'd7, 4'h0, 32'h0000_3001, 32'h0, 32'h1122_3344, 5'd8, 32'hAABB_CCDD, 0, 1, 0);
        op("sw",   3'd0, 4'hF, 32'h0000_1003, 32'hDEAD_BEEF, 32'h0, 5'd9, 32'h1234_5678, 3, 2, 0);
        op("stall",3'd5, 4'h0, 32'h0000_4000, 32'h0, 32'h0, 5'd10, 32'hCAFE_F00D, 0, 1, 4);
        op("nop",  3'd0, 4'h0, 32'h0000_5000, 32'h0, 32'h0, 5'd11, 32'h0, 0, 1, 0);

        // flush with a valid op in IDLE drops it
        in_valid = 1'b1; in_flush = 1'b1; in_ltype = 3'd5; in_addr = 32'h6000;
        @(negedge clk);
        in_valid = 1'b0; in_flush = 1'b0;
        chk("idle_flush.in_ready", in_ready, 1);
        chk("idle_flush.req", data_req, 0);

        // flush during WAIT: bus completes, no result
        in_valid = 1'b1; in_ltype = 3'd5; in_wstrb = 4'h0; in_addr = 32'h7000; in_waddr = 5'd12;
        @(negedge clk);
        in_valid = 1'b0;
        chk("wflush.req", data_req, 1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0; in_flush = 1'b1;
        @(negedge clk);
        in_flush = 1'b0;
        chk("wflush.not_idle", in_ready, 0);
        data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
        @(negedge clk);
        data_data_ok = 1'b0;
        chk("wflush.no_out", out_valid, 0);
        @(negedge clk);
        chk("wflush.idle", in_ready, 1);
        chk("wflush.no_out2", out_valid, 0);
        op("after_wflush", 3'd5, 4'h0, 32'h0000_7004, 32'h0, 32'h0, 5'd13, 32'h0BAD_F00D, 0, 1, 0);

        // flush while holding a result in DONE
        in_valid = 1'b1; in_ltype = 3'd1; in_addr = 32'h8001; in_waddr = 5'd14;
        @(negedge clk);
        in_valid = 1'b0;
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_7F00;
        @(negedge clk);
        data_data_ok = 1'b0;
        chk("dflush.valid_before", out_valid, 1);
        in_flush = 1'b1;
        #1;
        chk("dflush.valid_dropped", out_valid, 0);
        @(negedge clk);
        in_flush = 1'b0;
        chk("dflush.idle", in_ready, 1);
        chk("dflush.no_out", out_valid, 0);

        // reset mid-WAIT abandons the transaction
        in_valid = 1'b1; in_ltype = 3'd5; in_addr = 32'h9000; in_waddr = 5'd15;
        @(negedge clk);
        in_valid = 1'b0;
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rstwait.req", data_req, 0);
        chk("rstwait.out_valid", out_valid, 0);
        chk("rstwait.in_ready", in_ready, 1);
        chk("rstwait.out_wen", out_wen, 0);
        chk("rstwait.out_waddr", out_waddr, 0);
        data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        data_data_ok = 1'b0;
        chk("rstwait.stray_ok_ignored", out_valid, 0);
        chk("rstwait.still_idle", in_ready, 1);

        for (int n = 0; n < 40; n++) begin
            lt = 3'($urandom_range(0, 7));
            ws = 4'h0;
            if (lt == 3'd0 && $urandom_range(0, 3) != 0) ws = strb_tab[$urandom_range(0, 6)];
            op($sformatf("rnd%0d", n), lt, ws, $urandom, $urandom, $urandom, 5'($urandom),
               $urandom, $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
